// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the programmable-threshold UART-path FIFO.
// The read-port style is selected at compile time with the macro FIFO_FWFT_EN.
package fifo_pkg;

    // Default geometry: 8-bit words, 16 entries.
    localparam int DEF_B = 8;
    localparam int DEF_W = 4;

    // Legal ranges for the programmable thresholds and the address width.
    // The upper threshold bounds depend on W and are derived with fifo_depth().
    localparam int W_MIN      = 1;
    localparam int AF_THR_MIN = 1;
    localparam int AE_THR_MIN = 0;

    // Number of entries for a given address width.
    function automatic int fifo_depth(input int w);
        return 1 << w;
    endfunction

endpackage

// File: rtl/fifo_prog_chk.sv
// Elaboration-time legality checks on the fifo_prog parameters.
module fifo_prog_chk import fifo_pkg::*; #(
    parameter int W      = DEF_W,
    parameter int AF_THR = fifo_depth(DEF_W) - 2,
    parameter int AE_THR = 2
) ();

    if (W < W_MIN) begin : g_bad_w
        $error("fifo_prog: W=%0d below minimum %0d", W, W_MIN);
    end

    if ((AF_THR < AF_THR_MIN) || (AF_THR > fifo_depth(W))) begin : g_bad_af
        $error("fifo_prog: AF_THR=%0d outside 1..2**W", AF_THR);
    end

    if ((AE_THR < AE_THR_MIN) || (AE_THR > (fifo_depth(W) - 1))) begin : g_bad_ae
        $error("fifo_prog: AE_THR=%0d outside 0..2**W-1", AE_THR);
    end

endmodule

// File: rtl/fifo_ram.sv
// Storage array for fifo_prog: one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset.
module fifo_ram import fifo_pkg::*; #(
    parameter int B = DEF_B,
    parameter int W = DEF_W
) (
    input  logic         clk,
    input  logic         we,
    input  logic [W-1:0] waddr,
    input  logic [B-1:0] wdata,
    input  logic [W-1:0] raddr,
    output logic [B-1:0] rdata
);

    logic [B-1:0] mem_q [fifo_depth(W)];

    // Write port: store the word on an accepted write.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Read port: combinational view of the addressed entry.
    always_comb begin
        rdata = mem_q[raddr];
    end

endmodule

// File: rtl/fifo_prog.sv
// Synchronous FIFO with occupancy count, programmable almost-full/empty
// thresholds and sticky overflow/underflow flags.
// Define FIFO_FWFT_EN for a first-word-fall-through read port; otherwise
// read_data is a register loaded on each accepted read (1-cycle latency).
module fifo_prog import fifo_pkg::*; #(
    parameter int B      = DEF_B,
    parameter int W      = DEF_W,
    parameter int AF_THR = fifo_depth(W) - 2,
    parameter int AE_THR = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr,
    input  logic [B-1:0] write_data,
    input  logic         rd,
    output logic [B-1:0] read_data,
    output logic         empty,
    output logic         full,
    output logic         almost_empty,
    output logic         almost_full,
    output logic [W:0]   count,
    output logic         overflow,
    output logic         underflow,
    input  logic         clr_err
);

    localparam logic [W:0] DEPTH_V  = (W+1)'(fifo_depth(W));
    localparam logic [W:0] AF_THR_V = (W+1)'(AF_THR);
    localparam logic [W:0] AE_THR_V = (W+1)'(AE_THR);

    fifo_prog_chk #(.W(W), .AF_THR(AF_THR), .AE_THR(AE_THR)) u_chk ();

    logic [W-1:0] wr_ptr_q, wr_ptr_d;
    logic [W-1:0] rd_ptr_q, rd_ptr_d;
    logic [W:0]   count_q, count_d;
    logic         overflow_q, overflow_d;
    logic         underflow_q, underflow_d;
    logic         empty_s, full_s;
    logic         wr_acc_s, rd_acc_s;
    logic [B-1:0] ram_rdata_s;

    fifo_ram #(.B(B), .W(W)) u_ram (
        .clk   (clk),
        .we    (wr_acc_s),
        .waddr (wr_ptr_q),
        .wdata (write_data),
        .raddr (rd_ptr_q),
        .rdata (ram_rdata_s)
    );

    // Status decode from the registered count only.
    always_comb begin
        empty_s      = (count_q == {(W+1){1'b0}});
        full_s       = (count_q == DEPTH_V);
        empty        = empty_s;
        full         = full_s;
        almost_empty = (count_q <= AE_THR_V);
        almost_full  = (count_q >= AF_THR_V);
        count        = count_q;
        overflow     = overflow_q;
        underflow    = underflow_q;
    end

    // Acceptance: a full FIFO still takes a write when a read frees a slot.
    always_comb begin
        wr_acc_s = wr & (~full_s | rd);
        rd_acc_s = rd & ~empty_s;
    end

    // Next-state for pointers, occupancy and sticky error flags.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (wr_acc_s) begin
            wr_ptr_d = wr_ptr_q + W'(1'b1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (rd_acc_s) begin
            rd_ptr_d = rd_ptr_q + W'(1'b1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({wr_acc_s, rd_acc_s})
            2'b10:   count_d = count_q + (W+1)'(1'b1);
            2'b01:   count_d = count_q - (W+1)'(1'b1);
            default: count_d = count_q;
        endcase

        // A fresh error in the clearing cycle keeps the flag set.
        if (wr & full_s & ~rd) begin
            overflow_d = 1'b1;
        end else if (clr_err) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end

        if (rd & empty_s) begin
            underflow_d = 1'b1;
        end else if (clr_err) begin
            underflow_d = 1'b0;
        end else begin
            underflow_d = underflow_q;
        end
    end

    // State registers for pointers, count and error flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q    <= {W{1'b0}};
            rd_ptr_q    <= {W{1'b0}};
            count_q     <= {(W+1){1'b0}};
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

`ifdef FIFO_FWFT_EN
    // Fall-through read port: show the head word while data is present.
    always_comb begin
        if (empty_s) begin
            read_data = {B{1'b0}};
        end else begin
            read_data = ram_rdata_s;
        end
    end
`else
    logic [B-1:0] read_data_q, read_data_d;

    // Registered read port: capture the head word on an accepted read.
    always_comb begin
        if (rd_acc_s) begin
            read_data_d = ram_rdata_s;
        end else begin
            read_data_d = read_data_q;
        end
    end

    // Read data register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            read_data_q <= {B{1'b0}};
        end else begin
            read_data_q <= read_data_d;
        end
    end

    // Drive the port from the register.
    always_comb begin
        read_data = read_data_q;
    end
`endif

endmodule

// File: tb/tb_fifo_prog.sv
// Self-checking bench for fifo_prog (B=8, W=4, AF_THR=14, AE_THR=2):
// directed scenarios followed by random traffic, all compared against a
// queue-based reference model.
`timescale 1ns/1ps
module tb_fifo_prog;

    localparam int B = 8;
    localparam int W = 4;
    localparam int DEPTH = 16;
    localparam int AF = 14;
    localparam int AE = 2;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         wr = 1'b0;
    logic [B-1:0] write_data = 8'h00;
    logic         rd = 1'b0;
    logic [B-1:0] read_data;
    logic         empty, full, almost_empty, almost_full;
    logic [W:0]   count;
    logic         overflow, underflow;
    logic         clr_err = 1'b0;

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [B-1:0] q[$];
    logic [B-1:0] m_rdata = 8'h00;
    logic         m_ovf = 1'b0;
    logic         m_udf = 1'b0;

    fifo_prog #(.B(B), .W(W), .AF_THR(AF), .AE_THR(AE)) dut (
        .clk          (clk),
        .reset        (reset),
        .wr           (wr),
        .write_data   (write_data),
        .rd           (rd),
        .read_data    (read_data),
        .empty        (empty),
        .full         (full),
        .almost_empty (almost_empty),
        .almost_full  (almost_full),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow),
        .clr_err      (clr_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [B-1:0] exp_read_data();
`ifdef FIFO_FWFT_EN
        return (q.size() > 0) ? q[0] : 8'h00;
`else
        return m_rdata;
`endif
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".count"}, 32'(count), 32'(q.size()));
        chk({tag, ".empty"}, 32'(empty), 32'(q.size() == 0));
        chk({tag, ".full"}, 32'(full), 32'(q.size() == DEPTH));
        chk({tag, ".aempty"}, 32'(almost_empty), 32'(q.size() <= AE));
        chk({tag, ".afull"}, 32'(almost_full), 32'(q.size() >= AF));
        chk({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
        chk({tag, ".udf"}, 32'(underflow), 32'(m_udf));
        chk({tag, ".rdata"}, 32'(read_data), 32'(exp_read_data()));
    endtask

    task automatic model_reset();
        q.delete();
        m_rdata = 8'h00;
        m_ovf = 1'b0;
        m_udf = 1'b0;
    endtask

    // One clock cycle of traffic, model update, then a full check.
    task automatic step(input logic w, input logic [B-1:0] d, input logic r,
                        input logic c, input string tag);
        bit was_full, was_empty, wacc, racc;
        @(negedge clk);
        wr = w; write_data = d; rd = r; clr_err = c;
        @(posedge clk);
        was_full  = (q.size() == DEPTH);
        was_empty = (q.size() == 0);
        wacc = w && (!was_full || r);
        racc = r && !was_empty;
        if (racc) m_rdata = q.pop_front();
        if (wacc) q.push_back(d);
        if (w && was_full && !r) m_ovf = 1'b1;
        else if (c) m_ovf = 1'b0;
        if (r && was_empty) m_udf = 1'b1;
        else if (c) m_udf = 1'b0;
        #1;
        check_all(tag);
    endtask

    initial begin
        // 1. Reset held for 3 cycles
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        #1;
        check_all("reset");
        chk("reset.rdata_const", 32'(read_data), 32'h00);

        // 2. Ordering
        step(1'b1, 8'hA1, 1'b0, 1'b0, "ord_w");
        step(1'b1, 8'hB2, 1'b0, 1'b0, "ord_w");
        step(1'b1, 8'hC3, 1'b0, 1'b0, "ord_w");
        chk("ord.count3", 32'(count), 32'd3);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0, "ord_r");
`ifndef FIFO_FWFT_EN
        chk("ord.last_C3", 32'(read_data), 32'hC3);
`endif

        // 3. Fill, overflow, drain
        for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0, "fill");
        chk("fill.full", 32'(full), 32'd1);
        step(1'b1, 8'hFF, 1'b0, 1'b0, "fill_ovf");
        chk("fill.ovf_set", 32'(overflow), 32'd1);
        for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0, "drain");
`ifndef FIFO_FWFT_EN
        chk("drain.last_0F", 32'(read_data), 32'h0F);
`endif
        step(1'b0, 8'h00, 1'b0, 1'b1, "clr");

        // 4. Full with simultaneous read/write
        for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0, "refill");
        step(1'b1, 8'h55, 1'b1, 1'b0, "full_rw");
        chk("full_rw.count16", 32'(count), 32'd16);
        chk("full_rw.no_ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0, "drain2");
`ifndef FIFO_FWFT_EN
        chk("drain2.last_55", 32'(read_data), 32'h55);
`endif

        // 5. Wrap, underflow, clear
        for (int i = 0; i < 40; i++)
            step(1'b1, 8'($urandom), (i % 3) != 0, 1'b0, "wrap");
        while (q.size() > 0) step(1'b0, 8'h00, 1'b1, 1'b0, "wrap_drain");
        step(1'b0, 8'h00, 1'b1, 1'b0, "udf");
        chk("udf.set", 32'(underflow), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b1, "udf_clr");
        chk("udf.cleared", 32'(underflow), 32'd0);
        step(1'b1, 8'h77, 1'b1, 1'b0, "empty_rw");
        chk("empty_rw.count1", 32'(count), 32'd1);
        step(1'b0, 8'h00, 1'b1, 1'b1, "udf_vs_clr");

        // 6. Reset mid-operation
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, "pre_rst");
        @(negedge clk);
        wr = 1'b0; rd = 1'b0; clr_err = 1'b0;
        reset = 1'b0;
        model_reset();
        #1;
        check_all("mid_rst");
        chk("mid_rst.count0", 32'(count), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        step(1'b1, 8'h3C, 1'b0, 1'b0, "post_rst_w");
        step(1'b0, 8'h00, 1'b1, 1'b0, "post_rst_r");
`ifndef FIFO_FWFT_EN
        chk("post_rst.3C", 32'(read_data), 32'h3C);
`endif

        // Random traffic with alternating fill/drain bias
        for (int blk = 0; blk < 12; blk++) begin
            int pw = (blk % 2 == 0) ? 75 : 25;
            for (int i = 0; i < 40; i++) begin
                step(($urandom % 100) < pw, 8'($urandom), ($urandom % 100) >= pw,
                     ($urandom % 16) == 0, "rand");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
